score_bcd_scheduler: RTL and testbench

SCORE_BCD_SCHEDULER -- requirements
Module: score_bcd_scheduler

---
 rtl/score_bcd_scheduler.sv | 137 +++++++++++++
 tb/tb_score_bcd_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_scheduler.sv
// Two-requester score converter: one shared serial double-dabble engine.
// Optional SCORE_BCD_ROUND_ROBIN_EN: round-robin tie-break instead of fixed priority.
module score_bcd_scheduler #(
    parameter int BIN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [BIN_W-1:0] bin0,
    input  logic [BIN_W-1:0] bin1,
    output logic [1:0]       ack,
    output logic [1:0]       done,
    output logic             busy,
    output logic [3:0]       bcd0_lo,
    output logic [3:0]       bcd0_hi,
    output logic [3:0]       bcd1_lo,
    output logic [3:0]       bcd1_hi
);

    localparam int CW = $clog2(BIN_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       pend;
    logic [1:0]       cand;
    logic [1:0]       gnt;
    logic             gsel;
    logic [BIN_W-1:0] sreg;
    logic [3:0]       dlo;
    // tens digit never exceeds 6 for a 6-bit score, so 3 bits suffice
    // and it never needs the add-3 correction before a shift
    logic [2:0]       dhi;
    logic [3:0]       alo;
    logic [CW-1:0]    cnt;
    logic             start;
    logic             shift_en;
    logic             finish;

    assign cand = req | pend;
    assign alo  = (dlo > 4'd4) ? dlo + 4'd3 : dlo;

`ifdef SCORE_BCD_ROUND_ROBIN_EN
    logic last;

    // tie goes to the requester that was not served last
    always_comb begin
        gnt = cand;
        if (cand == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end

    // remember the most recent grantee; reset favours requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last <= 1'b1;
        else if (start) last <= gnt[1];
    end
`else
    // fixed priority: requester 0 wins ties
    always_comb begin
        gnt = 2'b00;
        if (cand[0])      gnt = 2'b01;
        else if (cand[1]) gnt = 2'b10;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cand != 2'b00) state_nx = SHIFT;
            SHIFT:   if (cnt == '0)     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state-decoded controls
    always_comb begin
        busy     = (state != IDLE);
        start    = (state == IDLE) && (cand != 2'b00);
        shift_en = (state == SHIFT);
        finish   = (state == DONE);
    end

    // pending flags, handshakes, shift engine and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 2'b00;
            ack     <= 2'b00;
            done    <= 2'b00;
            gsel    <= 1'b0;
            sreg    <= '0;
            dlo     <= 4'd0;
            dhi     <= 3'd0;
            cnt     <= '0;
            bcd0_lo <= 4'd0;
            bcd0_hi <= 4'd0;
            bcd1_lo <= 4'd0;
            bcd1_hi <= 4'd0;
        end else begin
            pend <= (pend | req) & ~(start ? gnt : 2'b00);
            ack  <= start ? gnt : 2'b00;
            done <= 2'b00;
            if (start) begin
                gsel <= gnt[1];
                sreg <= gnt[1] ? bin1 : bin0;
                dlo  <= 4'd0;
                dhi  <= 3'd0;
                cnt  <= CW'(BIN_W - 1);
            end
            if (shift_en) begin
                dlo  <= {alo[2:0], sreg[BIN_W-1]};
                dhi  <= {dhi[1:0], alo[3]};
                sreg <= sreg << 1;
                cnt  <= cnt - 1'b1;
            end
            if (finish) begin
                done <= gsel ? 2'b10 : 2'b01;
                if (gsel) begin
                    bcd1_lo <= dlo;
                    bcd1_hi <= {1'b0, dhi};
                end else begin
                    bcd0_lo <= dlo;
                    bcd0_hi <= {1'b0, dhi};
                end
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Bench for score_bcd_scheduler: BIN_W=4 instance against a scoreboard model
// plus an exhaustive BIN_W=6 sweep.
module tb_score_bcd_scheduler;

    localparam int W  = 4;
    localparam int W6 = 6;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req4  = 2'b00;
    logic [1:0]    req6  = 2'b00;
    logic [W-1:0]  b40   = '0;
    logic [W-1:0]  b41   = '0;
    logic [W6-1:0] b60   = '0;
    logic [W6-1:0] b61   = '0;
    logic [1:0]    ack4, done4, ack6, done6;
    logic          busy4, busy6;
    logic [3:0]    l40, h40, l41, h41, l60, h60, l61, h61;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    score_bcd_scheduler #(.BIN_W(W)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .bin0(b40), .bin1(b41),
        .ack(ack4), .done(done4), .busy(busy4),
        .bcd0_lo(l40), .bcd0_hi(h40), .bcd1_lo(l41), .bcd1_hi(h41)
    );

    score_bcd_scheduler #(.BIN_W(W6)) u6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .bin0(b60), .bin1(b61),
        .ack(ack6), .done(done6), .busy(busy6),
        .bcd0_lo(l60), .bcd0_hi(h60), .bcd1_lo(l61), .bcd1_hi(h61)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard model: a grant made in cycle c shows ack in c+1,
    // done and new digits in c+W+2, and the engine is free again in c+W+2
    logic [1:0] mp;
    int         free_at;
    int         mlo[2];
    int         mhi[2];
    logic [1:0] exp_ack[int];
    logic [1:0] exp_done[int];
    int         exp_v[int];
    logic [1:0] r, w, ea, ed;
    int         v;
`ifdef SCORE_BCD_ROUND_ROBIN_EN
    logic       mlast;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ack", ack4, 0);
            chk("rst_done", done4, 0);
            chk("rst_busy", busy4, 0);
            chk("rst_bcd", {h41, l41, h40, l40}, 0);
            mp      = 2'b00;
            free_at = 0;
            mlo[0]  = 0; mlo[1] = 0;
            mhi[0]  = 0; mhi[1] = 0;
            exp_ack.delete();
            exp_done.delete();
            exp_v.delete();
`ifdef SCORE_BCD_ROUND_ROBIN_EN
            mlast = 1'b1;
`endif
        end else begin
            ea = exp_ack.exists(cyc) ? exp_ack[cyc] : 2'b00;
            ed = exp_done.exists(cyc) ? exp_done[cyc] : 2'b00;
            chk("ack", ack4, ea);
            chk("done", done4, ed);
            if (ed != 2'b00) begin
                v = exp_v[cyc];
                mlo[ed[1]] = v % 10;
                mhi[ed[1]] = v / 10;
            end
            chk("lo0", l40, mlo[0]);
            chk("hi0", h40, mhi[0]);
            chk("lo1", l41, mlo[1]);
            chk("hi1", h41, mhi[1]);
            chk("busy", busy4, (cyc < free_at) ? 1 : 0);
            r = req4 | mp;
            if (cyc >= free_at && r != 2'b00) begin
`ifdef SCORE_BCD_ROUND_ROBIN_EN
                if (r == 2'b11) w = mlast ? 2'b01 : 2'b10;
                else            w = r;
                mlast = w[1];
`else
                w = r[0] ? 2'b01 : 2'b10;
`endif
                v = w[1] ? int'(b41) : int'(b40);
                exp_ack[cyc + 1]     = w;
                exp_done[cyc + W + 2] = w;
                exp_v[cyc + W + 2]    = v;
                free_at = cyc + W + 2;
                mp = r & ~w;
            end else begin
                mp = r;
            end
        end
    end

    logic [1:0] wt;
    int         t;
    int         ca;

    initial begin
        tick(3);
        rst_n = 1'b1;

        // single request, 13 -> 1,3
        b40 = 4'd13; req4 = 2'b01; tick(); req4 = 2'b00;
        chk("t1_ack", ack4, 1);
        tick(5);
        chk("t1_done", done4, 1);
        chk("t1_hi", h40, 1);
        chk("t1_lo", l40, 3);
        chk("t1_b1", {h41, l41}, 0);

        // simultaneous requests, 0 then 1, acks 6 apart
        b40 = 4'd9; b41 = 4'd15; req4 = 2'b11; tick(); req4 = 2'b00;
        chk("t2_ack0", ack4, 1);
        tick(6);
        chk("t2_ack1", ack4, 2);
        tick(6);
        chk("t2_b0", {h40, l40}, 9);
        chk("t2_hi1", h41, 1);
        chk("t2_lo1", l41, 5);

        // tie-break after a grant to requester 0
        b40 = 4'd4; req4 = 2'b01; tick(); req4 = 2'b00;
        tick(6);
        b40 = 4'd2; b41 = 4'd3; req4 = 2'b11; tick(); req4 = 2'b00;
`ifdef SCORE_BCD_ROUND_ROBIN_EN
        chk("t3_tie", ack4, 2);
`else
        chk("t3_tie", ack4, 1);
`endif
        tick(12);

        // re-request during own conversion with a new value
        b40 = 4'd7; req4 = 2'b01; tick(); req4 = 2'b00;
        tick();
        b40 = 4'd8; req4 = 2'b01; tick(); req4 = 2'b00;
        tick(14);
        chk("t4_lo", l40, 8);
        chk("t4_hi", h40, 0);

        // reset during the second shift cycle
        b40 = 4'd5; req4 = 2'b01; tick(); req4 = 2'b00;
        tick();
        rst_n = 1'b0;
        tick(2);
        chk("t5_busy", busy4, 0);
        chk("t5_done", done4, 0);
        chk("t5_bcd", {h41, l41, h40, l40}, 0);
        rst_n = 1'b1;
        b40 = 4'd11; req4 = 2'b01; tick(); req4 = 2'b00;
        tick(6);
        chk("t5_lo", l40, 1);
        chk("t5_hi", h40, 1);

        // random traffic, each requester holds its value until acked
        wt = 2'b00;
        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                if (ack4[i]) wt[i] = 1'b0;
                req4[i] = 1'b0;
                if (!wt[i] && $urandom_range(0, 3) == 0) begin
                    if (i == 0) b40 = W'($urandom_range(0, 15));
                    else        b41 = W'($urandom_range(0, 15));
                    req4[i] = 1'b1;
                    wt[i]   = 1'b1;
                end
            end
            tick();
        end
        req4 = 2'b00;
        tick(20);

        // exhaustive sweep on the 6-bit instance
        for (int val = 0; val < 64; val++) begin
            for (int i = 0; i < 2; i++) begin
                if (i == 0) b60 = W6'(val);
                else        b61 = W6'(val);
                req6 = 2'b01 << i;
                tick();
                req6 = 2'b00;
                t = 0;
                while (!ack6[i] && t < 20) begin tick(); t++; end
                if (t == 20) chk("s_ack_to", 0, 1);
                ca = cyc;
                t = 0;
                while (!done6[i] && t < 20) begin tick(); t++; end
                if (t == 20) chk("s_done_to", 0, 1);
                chk("s_lat", cyc - ca, 7);
                if (i == 0) begin
                    chk("s_lo0", l60, val % 10);
                    chk("s_hi0", h60, val / 10);
                end else begin
                    chk("s_lo1", l61, val % 10);
                    chk("s_hi1", h61, val / 10);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
